// File: rtl/sdr_pkg.sv
// Shared SDR definitions: AGC bus states, gain register
// address and the gain width used by the demodulator.
package sdr_pkg;

  typedef enum logic [1:0] {
    BUS_IDLE,
    BUS_REQ,
    BUS_WAIT
  } bus_state_e;

  localparam logic [1:0] GAIN_REG_ADDR = 2'b00;
  localparam int         GAIN_W        = 16;

endpackage

// File: rtl/am_audio_agc_peak_window.sv
// Per-window peak magnitude of the audio stream; pulses
// peak_valid for one cycle after each window completes.
module agc_peak_window #(
  parameter int IW       = 8,
  parameter int LGWINDOW = 10
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_ce,
  input  logic [IW-1:0] i_sample,
  output logic          o_peak_valid,
  output logic [IW-2:0] o_peak
);

  localparam logic [IW-2:0] ONE_M =
    {{(IW-2){1'b0}}, 1'b1};
  localparam logic [LGWINDOW-1:0] ONE_C =
    {{(LGWINDOW-1){1'b0}}, 1'b1};

  logic [LGWINDOW-1:0] cnt_q, cnt_d;
  logic [IW-2:0]       run_q, run_d;
  logic [IW-2:0]       peak_q, peak_d;
  logic                valid_q, valid_d;
  logic [IW-2:0]       mag, max_v;

  always_comb begin
    mag = i_sample[IW-2:0];
    // most-negative input has no positive twin: saturate
    if (i_sample[IW-1]) begin
      if (i_sample[IW-2:0] == '0) mag = '1;
      else mag = (~i_sample[IW-2:0]) + ONE_M;
    end
    max_v = (mag > run_q) ? mag : run_q;
  end

  always_comb begin
    cnt_d   = cnt_q;
    run_d   = run_q;
    peak_d  = peak_q;
    valid_d = 1'b0;
    if (i_ce) begin
      cnt_d = cnt_q + ONE_C;
      if (&cnt_q) begin
        peak_d  = max_v;
        run_d   = '0;
        valid_d = 1'b1;
      end else begin
        run_d = max_v;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q   <= '0;
      run_q   <= '0;
      peak_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      peak_q  <= peak_d;
      valid_q <= valid_d;
    end
  end

  assign o_peak_valid = valid_q;
  assign o_peak       = peak_q;

endmodule

// File: rtl/am_audio_agc.sv
// Audio AGC: steps a 16-bit gain toward a peak band and pushes
// each new gain to the demodulator over pipelined Wishbone.
module am_audio_agc
  import sdr_pkg::*;
#(
  parameter int                IW           = 8,
  parameter int                LGWINDOW     = 10,
  parameter logic [IW-1:0]     TARGET_LO    = 8'd48,
  parameter logic [IW-1:0]     TARGET_HI    = 8'd96,
  parameter int                ATTACK_SHIFT = 3,
  parameter int                DECAY_SHIFT  = 6,
  parameter logic [GAIN_W-1:0] INITIAL_GAIN = 16'h4000,
  parameter logic [GAIN_W-1:0] MIN_GAIN     = 16'h0040,
  parameter logic [GAIN_W-1:0] MAX_GAIN     = 16'hffff,
  parameter int                LGTIMEOUT    = 8
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_agc_en,
  input  logic              i_ce,
  input  logic [IW-1:0]     i_sample,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [1:0]        o_wb_addr,
  output logic [31:0]       o_wb_data,
  output logic [3:0]        o_wb_sel,
  input  logic              i_wb_stall,
  input  logic              i_wb_ack,
  input  logic              i_wb_err,
  output logic [GAIN_W-1:0] o_gain,
  output logic [IW-2:0]     o_peak,
  output logic              o_timeout
);

  localparam logic [LGTIMEOUT-1:0] ONE_T =
    {{(LGTIMEOUT-1){1'b0}}, 1'b1};

  logic          pk_valid;
  logic [IW-2:0] peak;

  agc_peak_window #(
    .IW       (IW),
    .LGWINDOW (LGWINDOW)
  ) u_peak (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_ce         (i_ce),
    .i_sample     (i_sample),
    .o_peak_valid (pk_valid),
    .o_peak       (peak)
  );

  logic [GAIN_W-1:0]    gain_q, gain_d;
  logic [GAIN_W-1:0]    data_q, data_d;
  logic [LGTIMEOUT-1:0] tcnt_q, tcnt_d;
  bus_state_e           state_q, state_d;
  logic                 pend_q, pend_d;
  logic                 cyc_q, cyc_d;
  logic                 stb_q, stb_d;
  logic                 tmo_q, tmo_d;
  logic [GAIN_W:0]      up;
  logic [GAIN_W-1:0]    dn;
  logic                 gain_chg;
  logic                 pend_set, pend_clr;
  logic                 live;

  always_comb begin
    up = {1'b0, gain_q} + {1'b0, gain_q >> DECAY_SHIFT};
    dn = gain_q - (gain_q >> ATTACK_SHIFT);
    gain_d = gain_q;
    if (pk_valid && i_agc_en) begin
      if ({1'b0, peak} > TARGET_HI)
        gain_d = (dn < MIN_GAIN) ? MIN_GAIN : dn;
      else if ({1'b0, peak} < TARGET_LO)
        gain_d = (up > {1'b0, MAX_GAIN}) ?
                 MAX_GAIN : up[GAIN_W-1:0];
    end
    gain_chg = (gain_d != gain_q);
  end

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    stb_d    = stb_q;
    data_d   = data_q;
    tmo_d    = tmo_q;
    tcnt_d   = tcnt_q;
    pend_set = gain_chg;
    pend_clr = 1'b0;
    live     = 1'b0;
    unique case (state_q)
      BUS_IDLE: begin
        if (pend_q && i_agc_en) begin
          data_d   = gain_q;
          pend_clr = 1'b1;
          cyc_d    = 1'b1;
          stb_d    = 1'b1;
          tcnt_d   = '0;
          state_d  = BUS_REQ;
        end
      end
      BUS_REQ, BUS_WAIT: begin
        tcnt_d = tcnt_q + ONE_T;
        // a response only counts once the strobe is taken
        live = (state_q == BUS_WAIT) || !i_wb_stall;
        if (state_q == BUS_REQ && !i_wb_stall) begin
          stb_d   = 1'b0;
          state_d = BUS_WAIT;
        end
        if (live && i_wb_ack) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          tmo_d   = 1'b0;
          state_d = BUS_IDLE;
        end else if (live && i_wb_err) begin
          cyc_d    = 1'b0;
          stb_d    = 1'b0;
          pend_set = 1'b1;
          state_d  = BUS_IDLE;
        end else if (&tcnt_q) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          tmo_d   = 1'b1;
          state_d = BUS_IDLE;
        end
      end
      default: state_d = BUS_IDLE;
    endcase
    pend_d = pend_set | (pend_q & ~pend_clr);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      gain_q  <= INITIAL_GAIN;
      data_q  <= '0;
      tcnt_q  <= '0;
      state_q <= BUS_IDLE;
      pend_q  <= 1'b1;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      gain_q  <= gain_d;
      data_q  <= data_d;
      tcnt_q  <= tcnt_d;
      state_q <= state_d;
      pend_q  <= pend_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      tmo_q   <= tmo_d;
    end
  end

  assign o_wb_cyc  = cyc_q;
  assign o_wb_stb  = stb_q;
  assign o_wb_we   = cyc_q;
  assign o_wb_addr = GAIN_REG_ADDR;
  assign o_wb_data = {{(32-GAIN_W){1'b0}}, data_q};
  assign o_wb_sel  = 4'b0011;
  assign o_gain    = gain_q;
  assign o_peak    = peak;
  assign o_timeout = tmo_q;

endmodule

// File: doc/am_audio_agc.md
Name: am_audio_agc

Overview:
- Automatic gain control placed directly downstream of the AM demodulator's carrier-removed audio stream (8-bit signed, one strobe per audio sample).
- Measures the peak magnitude over fixed windows and steps a 16-bit gain toward a target band.
- Pushes each new gain into the demodulator's gain register (bus address 2'b00) as a Wishbone pipelined master.
- Replaces manual gain writes from the host when i_agc_en is high.

Parameters:
- IW, 8, input sample width (signed)
- LGWINDOW, 10, log2 of samples per measurement window
- TARGET_LO, 8'd48, peak below this raises gain
- TARGET_HI, 8'd96, peak above this lowers gain
- ATTACK_SHIFT, 3, decrease step = gain >> ATTACK_SHIFT
- DECAY_SHIFT, 6, increase step = gain >> DECAY_SHIFT
- INITIAL_GAIN, 16'h4000, gain after reset
- MIN_GAIN, 16'h0040, lower clamp
- MAX_GAIN, 16'hffff, upper clamp
- LGTIMEOUT, 8, log2 of cycles to wait for ack before abandoning a write

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  reset, asynchronous, active-low
- i_agc_en  in  1  1 = AGC runs and issues bus writes; 0 = hold gain, no writes
- i_ce  in  1  sample strobe
- i_sample  in  IW  signed audio sample, valid when i_ce
- o_wb_cyc  out  1  bus cycle
- o_wb_stb  out  1  bus strobe
- o_wb_we  out  1  always 1 during a cycle
- o_wb_addr  out  2  always 2'b00 (gain register)
- o_wb_data  out  32  {16'h0, gain}
- o_wb_sel  out  4  4'b0011
- i_wb_stall  in  1  slave stall
- i_wb_ack  in  1  slave ack
- i_wb_err  in  1  slave error
- o_gain  out  16  current gain value
- o_peak  out  IW-1  peak of last completed window
- o_timeout  out  1  sticky; set on abandoned write, cleared by the next successful ack

Behaviour:
- Reset (async assert, sync release):
  - o_gain = INITIAL_GAIN; o_peak = 0.
  - Sample counter = 0; running peak = 0.
  - Pending flag = 1, so INITIAL_GAIN is written once after reset when i_agc_en is high.
  - Bus state IDLE; o_wb_cyc = o_wb_stb = 0; o_timeout = 0.
- Magnitude per sample: |x|, with the most-negative input (-128 for IW=8) saturated to 127.
  - Running peak = max(running peak, |x|) on each i_ce.
- Window: counter increments on each i_ce; wraps at 2^LGWINDOW-1.
  - On the wrapping sample, that sample's |x| is included in the window.
  - o_peak <= final peak; running peak <= 0.
  - A gain update is scheduled for the next cycle.
- Gain update (one cycle after the window end):
  - peak > TARGET_HI: gain -= gain>>ATTACK_SHIFT, clamped to ≥ MIN_GAIN.
  - peak < TARGET_LO: gain += gain>>DECAY_SHIFT, computed at 17 bits and clamped to ≤ MAX_GAIN.
  - Otherwise: hold.
  - If the result differs from the old gain, set pending.
  - When i_agc_en = 0: no update occurs; windows still run and o_peak still updates.
- Bus FSM:
  - IDLE: if pending and i_agc_en, latch o_wb_data = {16'h0, o_gain}, clear pending, assert cyc+stb, go to REQ.
  - REQ: on !i_wb_stall, drop stb and go to WAIT.
  - WAIT: cyc held.
    - On i_wb_ack: drop cyc, clear o_timeout, go to IDLE.
    - On i_wb_err: drop cyc, set pending (retry), go to IDLE.
  - Timeout: in REQ or WAIT, a counter runs from cycle entry. At 2^LGTIMEOUT cycles, drop cyc/stb, set o_timeout, go to IDLE, and leave pending as is.
  - Ack arriving in the same cycle stb is accepted (REQ with !stall and ack): treated as complete, back to IDLE.
- A gain change during REQ/WAIT sets pending. The latched o_wb_data is not altered mid-cycle; the newer value is written after the current cycle completes.
- i_agc_en falling mid-cycle: the current cycle finishes normally; no new cycle starts.
- Latency:
  - Window-end i_ce at cycle N → o_peak valid N+1, o_gain valid N+2.
  - From IDLE with pending set, o_wb_stb asserts N+3.
- i_ce samples arriving during any bus state are never dropped; measurement is independent of the bus.

Decomposition:
- Shared package `sdr_pkg`:
  - bus-state enum (IDLE/REQ/WAIT)
  - gain-register address constant 2'b00
  - 16-bit gain width constant, shared with the demodulator's gain register
- One sub-module `agc_peak_window`: abs/saturate, running max, window counter. Outputs {peak_valid, peak}.
- Gain arithmetic and bus FSM stay in the top module.

Test Plan:
- Reset, i_agc_en=1, slave acks after 1 cycle → one write, o_wb_data=32'h0000_4000, o_wb_sel=4'b0011, then bus idle.
- 1024 samples of ±120 (peak 120 > 96) → o_gain 16'h4000→16'h3800, write of 32'h0000_3800 issued.
- 1024 samples of ±10 → o_gain 16'h4000→16'h4100. With o_gain near 16'hFF00 repeated windows saturate at 16'hffff, and no write occurs once gain is unchanged.
- Single sample -128 in an otherwise zero window → o_peak = 127.
- Slave never acks → after 256 cycles cyc drops and o_timeout=1. Next window's write is acked → o_timeout=0.
- i_wb_err on the first write → the same gain is rewritten next. Assert i_reset_n=0 mid-WAIT → cyc/stb drop asynchronously and o_gain=16'h4000.
